seq_mul_hs: RTL and testbench
=============================

Name: seq_mul_hs

Overview:
- Parametrised iterative shift-add multiplier with a valid/ready handshake on both the input and the output.
- Successor to the fixed-width unsigned mantissa multiplier. Adds generic width, a per-transaction signed/unsigned mode, a zero-operand early exit and back-pressure.
- Sits in the FP multiplier datapath: the mantissa product path uses it with N=24, hidden bit included. It is also usable standalone for integer multiply.

Parameters:
- N, 24, operand width in bits (N >= 2).
- ZERO_SKIP, 1, when 1 a zero operand bypasses iteration (2-cycle latency).

Ports:
- clk  in  1  clock, rising edge.
- rstn  in  1  reset, synchronous, active-low.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block can accept operands.
- a  in  N  multiplicand.
- b  in  N  multiplier.
- is_signed  in  1  1 = two's-complement operands, 0 = unsigned; latched with a/b.
- out_valid  out  1  product valid.
- out_ready  in  1  consumer accepts product.
- p  out  2N  product.
- busy  out  1  high in CALC or DONE.

Behaviour:
- Clock and reset: single clock clk; reset rstn is synchronous and active-low. No asynchronous reset anywhere.
- Reset (rstn=0 at a rising edge):
  - State to IDLE, p=0, out_valid=0, cnt=0, internal M/A/Q/neg=0.
  - in_ready=1 and busy=0 from the first cycle after reset.
  - Reset mid-CALC or mid-DONE abandons the transaction; no output is produced.
- FSM states: IDLE, CALC, DONE.
- in_ready = (state==IDLE). busy = !in_ready.
- IDLE, on an edge with in_valid && in_ready:
  - Latch M = |a| and Q = |b| as N-bit magnitudes. Magnitudes are taken only if is_signed=1; -2^(N-1) maps to 2^(N-1), which fits in N bits.
  - Latch neg = is_signed & (a[N-1] ^ b[N-1]).
  - Clear A (N+1 bits) and cnt.
  - If ZERO_SKIP=1 and (a==0 or b==0): go to DONE with p=0; out_valid rises one edge after accept.
  - Otherwise go to CALC.
- CALC, one multiplier bit per cycle:
  - S = A + (Q[0] ? M : 0), computed N+1 bits wide.
  - {A,Q} <= {S,Q} >> 1.
  - cnt <= cnt + 1.
  - On the edge where cnt==N-1: mag = the 2N-bit shifted result; p <= neg ? (~mag + 1) : mag; state <= DONE.
  - Latency: accept edge to out_valid high = N edges (N+1 edges counting the DONE register).
  - a, b, is_signed and in_valid are ignored during CALC.
- DONE:
  - out_valid=1. p is held stable while out_valid && !out_ready.
  - On an edge with out_ready=1: out_valid <= 0, state <= IDLE.
  - There is no same-cycle accept of new operands. Back-to-back throughput is one product per N+2 cycles.
  - p retains its last value after leaving DONE. Consumers must qualify p with out_valid.
- Width rules:
  - The unsigned product fits exactly in 2N bits, so there is no overflow.
  - The signed product is exact in 2N-bit two's complement. (-2^(N-1))^2 = 2^(2N-2) is representable.
- out_ready while out_valid=0 has no effect.
- in_valid held high across DONE is accepted only after returning to IDLE.

Decomposition:
- Package mul_pkg holds:
  - typedef enum logic [1:0] {IDLE, CALC, DONE} mul_state_t.
  - Function cnt_w(N) = $clog2(N).
  - Function abs_n and neg_2n helpers, written width-generic via parameterised class or macro-free static functions.
- No sub-module. The datapath (adder plus shift register) and the FSM stay in one module of roughly 150–200 lines.

Test Plan:
- N=8, unsigned: a=8'hFF, b=8'hFF -> p=16'hFE01; out_valid rises exactly 8 edges after the accept edge.
- N=8, signed: a=8'h80 (-128), b=8'hFF (-1) -> p=16'h0080. Then a=8'h80, b=8'h80 -> p=16'h4000.
- N=8, signed: a=8'h07, b=8'hFD (-3) -> p=16'hFFEB. Same operands with is_signed=0 -> p=16'h06EB.
- ZERO_SKIP=1, N=24: a=0, b=24'hABCDEF -> p=0 with out_valid one edge after accept. With ZERO_SKIP=0 -> p=0 after 24 edges.
- Back-pressure: hold out_ready=0 for 5 cycles after out_valid -> p stable and in_ready=0 throughout. Raise out_ready -> in_ready=1 on the next cycle. in_valid pulses during CALC are ignored.
- Reset mid-CALC: assert rstn=0 at cnt=3 -> next cycle out_valid=0, p=0, in_ready=1. The following transaction (a=3, b=5) yields p=15.
- Random soak (N=24, both modes, 10k vectors): compare against a reference model; no handshake violations.

Source files
------------

// File: rtl/mul_pkg.sv
// rtl/mul_pkg.sv - shared state type and width-generic helpers for seq_mul_hs
package mul_pkg;

    typedef enum logic [1:0] {IDLE, CALC, DONE} mul_state_t;

    // Helpers operate on a fixed 64-bit container; the live width is an argument.
    localparam int MAXW = 64;

    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic logic [MAXW-1:0] width_mask(input int n);
        return (n >= MAXW) ? {MAXW{1'b1}} : ((MAXW'(1) << n) - MAXW'(1));
    endfunction

    // -2^(n-1) maps to 2^(n-1), which still fits in n unsigned bits.
    function automatic logic [MAXW-1:0] abs_n(input logic [MAXW-1:0] x, input int n);
        logic [MAXW-1:0] xm;
        xm = x & width_mask(n);
        return xm[n-1] ? ((~xm + MAXW'(1)) & width_mask(n)) : xm;
    endfunction

    function automatic logic [MAXW-1:0] neg_2n(input logic [MAXW-1:0] x, input int n2);
        return (~x + MAXW'(1)) & width_mask(n2);
    endfunction

endpackage

// File: rtl/seq_mul_hs.sv
// rtl/seq_mul_hs.sv - iterative shift-add multiplier, signed/unsigned, valid/ready on both sides
module seq_mul_hs
    import mul_pkg::*;
#(
    parameter int N         = 24,
    parameter bit ZERO_SKIP = 1'b1
) (
    input  logic           clk,
    input  logic           rstn,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    input  logic           is_signed,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-1:0] p,
    output logic           busy
);

    localparam int CW = cnt_w(N);

    mul_state_t      state;
    logic [N-1:0]    m_reg;
    logic [N-1:0]    q_reg;
    logic [N:0]      acc;
    logic            neg;
    logic [CW-1:0]   cnt;

    logic [MAXW-1:0] a_abs_w;
    logic [MAXW-1:0] b_abs_w;
    logic [MAXW-1:0] negmag_w;
    logic [N:0]      sum;
    logic [2*N:0]    shifted;
    logic [2*N-1:0]  mag;
    logic [2*N-1:0]  p_next;
    logic            zero_op;

    assign a_abs_w = is_signed ? abs_n(MAXW'(a), N) : MAXW'(a);
    assign b_abs_w = is_signed ? abs_n(MAXW'(b), N) : MAXW'(b);
    assign zero_op = ZERO_SKIP && ((a == '0) || (b == '0));

    // One multiplier bit per cycle: add M when Q[0] is set, then shift {A,Q} right.
    assign sum      = acc + (q_reg[0] ? {1'b0, m_reg} : '0);
    assign shifted  = {sum, q_reg} >> 1;
    assign mag      = shifted[2*N-1:0];
    assign negmag_w = neg_2n(MAXW'(mag), 2 * N);
    assign p_next   = neg ? negmag_w[2*N-1:0] : mag;

    assign in_ready = (state == IDLE);
    assign busy     = !in_ready;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state     <= IDLE;
            p         <= '0;
            out_valid <= 1'b0;
            cnt       <= '0;
            m_reg     <= '0;
            q_reg     <= '0;
            acc       <= '0;
            neg       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        m_reg <= a_abs_w[N-1:0];
                        q_reg <= b_abs_w[N-1:0];
                        neg   <= is_signed & (a[N-1] ^ b[N-1]);
                        acc   <= '0;
                        cnt   <= '0;
                        if (zero_op) begin
                            p     <= '0;
                            state <= DONE;
                        end else begin
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    acc <= shifted[2*N:N];
                    q_reg <= shifted[N-1:0];
                    cnt <= cnt + CW'(1);
                    if (cnt == CW'(N - 1)) begin
                        p         <= p_next;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    // Zero-skip enters DONE with out_valid low; it rises on the following edge.
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_mul_hs.sv
// tb/tb_seq_mul_hs.sv - randomized self-checking bench for seq_mul_hs at N=8 and N=24
module tb_seq_mul_hs;

    logic        clk = 1'b0;
    logic        rstn;
    logic [23:0] a_s;
    logic [23:0] b_s;
    logic        sg_s;
    logic        iv [3];
    logic        ordy [3];
    logic        ir [3];
    logic        ov [3];
    logic        bz [3];
    logic [47:0] pv [3];
    logic [15:0] p0;
    logic [47:0] p1;
    logic [47:0] p2;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    seq_mul_hs #(.N(8), .ZERO_SKIP(1'b1)) dut0 (
        .clk(clk), .rstn(rstn), .in_valid(iv[0]), .in_ready(ir[0]), .a(a_s[7:0]), .b(b_s[7:0]),
        .is_signed(sg_s), .out_valid(ov[0]), .out_ready(ordy[0]), .p(p0), .busy(bz[0]));
    seq_mul_hs #(.N(24), .ZERO_SKIP(1'b1)) dut1 (
        .clk(clk), .rstn(rstn), .in_valid(iv[1]), .in_ready(ir[1]), .a(a_s), .b(b_s),
        .is_signed(sg_s), .out_valid(ov[1]), .out_ready(ordy[1]), .p(p1), .busy(bz[1]));
    seq_mul_hs #(.N(24), .ZERO_SKIP(1'b0)) dut2 (
        .clk(clk), .rstn(rstn), .in_valid(iv[2]), .in_ready(ir[2]), .a(a_s), .b(b_s),
        .is_signed(sg_s), .out_valid(ov[2]), .out_ready(ordy[2]), .p(p2), .busy(bz[2]));

    assign pv[0] = {32'd0, p0};
    assign pv[1] = p1;
    assign pv[2] = p2;

    function automatic int width_of(input int d);
        return (d == 0) ? 8 : 24;
    endfunction

    function automatic bit zs_of(input int d);
        return d != 2;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: interpret operands as integers, multiply, keep 2N bits.
    function automatic logic [47:0] ref_mul(input int n, input logic [23:0] x, input logic [23:0] y, input bit sg);
        longint vx, vy, pr;
        longint mask;
        vx = longint'(x) & ((longint'(1) << n) - 1);
        vy = longint'(y) & ((longint'(1) << n) - 1);
        if (sg && x[n-1]) vx = vx - (longint'(1) << n);
        if (sg && y[n-1]) vy = vy - (longint'(1) << n);
        pr = vx * vy;
        mask = (longint'(1) << (2 * n)) - 1;
        return 48'(pr & mask);
    endfunction

    function automatic int ref_lat(input int d, input logic [23:0] x, input logic [23:0] y);
        int n;
        logic [23:0] m;
        n = width_of(d);
        m = 24'((32'd1 << n) - 1);
        if (zs_of(d) && (((x & m) == 0) || ((y & m) == 0))) return 1;
        return n;
    endfunction

    // Full transaction on DUT d; noise drives junk in_valid/operands while the DUT is busy.
    task automatic run_txn(input int d, input logic [23:0] x, input logic [23:0] y, input bit sg,
                           input logic [47:0] exp_p, input int exp_lat, input int hold, input bit noise);
        int lat;
        @(negedge clk);
        chk("in_ready_before", ir[d], 1'b1);
        a_s = x; b_s = y; sg_s = sg; iv[d] = 1'b1;
        @(posedge clk);
        lat = 0;
        @(negedge clk);
        iv[d] = 1'b0;
        chk("busy_after_accept", {ir[d], bz[d]}, 2'b01);
        while (!ov[d] && lat < 200) begin
            if (noise) begin
                iv[d] = 1'($urandom); a_s = 24'($urandom); b_s = 24'($urandom); sg_s = 1'($urandom);
            end
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        iv[d] = 1'b0;
        if (!ov[d]) begin
            chk("timeout_out_valid", 1'b0, 1'b1);
            return;
        end
        chk("latency", 64'(lat), 64'(exp_lat));
        chk("product", pv[d], exp_p);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk("hold_state", {ov[d], ir[d]}, 2'b10);
            chk("hold_product", pv[d], exp_p);
        end
        ordy[d] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ordy[d] = 1'b0;
        chk("release_state", {ov[d], ir[d], bz[d]}, 3'b010);
        chk("p_retained", pv[d], exp_p);
    endtask

    initial begin
        logic [23:0] x, y;
        bit sg;
        int d, n;
        rstn = 1'b0; a_s = '0; b_s = '0; sg_s = 1'b0;
        for (int i = 0; i < 3; i++) begin iv[i] = 1'b0; ordy[i] = 1'b0; end
        repeat (3) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        for (int i = 0; i < 3; i++)
            chk("reset_state", {ov[i], ir[i], bz[i], pv[i]}, {3'b010, 48'd0});

        run_txn(0, 24'hFF, 24'hFF, 1'b0, 48'hFE01, 8, 0, 1'b0);
        run_txn(0, 24'h80, 24'hFF, 1'b1, 48'h0080, 8, 0, 1'b0);
        run_txn(0, 24'h80, 24'h80, 1'b1, 48'h4000, 8, 0, 1'b0);
        run_txn(0, 24'h07, 24'hFD, 1'b1, 48'hFFEB, 8, 0, 1'b0);
        run_txn(0, 24'h07, 24'hFD, 1'b0, 48'h06EB, 8, 0, 1'b0);
        run_txn(1, 24'h0, 24'hABCDEF, 1'b0, 48'h0, 1, 0, 1'b0);
        run_txn(2, 24'h0, 24'hABCDEF, 1'b0, 48'h0, 24, 0, 1'b0);
        run_txn(1, 24'h800000, 24'h800000, 1'b1, 48'h400000000000, 24, 0, 1'b0);
        run_txn(0, 24'h35, 24'hC6, 1'b1, ref_mul(8, 24'h35, 24'hC6, 1'b1), 8, 5, 1'b1);

        // Abandon a transaction part-way through CALC.
        @(negedge clk);
        a_s = 24'h5A; b_s = 24'h33; sg_s = 1'b0; iv[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        iv[0] = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rstn = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        chk("mid_calc_reset", {ov[0], ir[0], pv[0]}, {2'b01, 48'd0});
        run_txn(0, 24'd3, 24'd5, 1'b0, 48'd15, 8, 0, 1'b0);

        for (int k = 0; k < 1200; k++) begin
            d  = int'($urandom_range(0, 2));
            n  = width_of(d);
            sg = 1'($urandom);
            case ($urandom_range(0, 7))
                0: x = 24'd0;
                1: x = 24'(32'd1 << (n - 1));
                2: x = 24'hFFFFFF;
                default: x = 24'($urandom);
            endcase
            case ($urandom_range(0, 7))
                0: y = 24'd0;
                1: y = 24'(32'd1 << (n - 1));
                2: y = 24'd1;
                default: y = 24'($urandom);
            endcase
            if (n == 8) begin x = x & 24'hFF; y = y & 24'hFF; end
            run_txn(d, x, y, sg, ref_mul(n, x, y, sg), ref_lat(d, x, y),
                    int'($urandom_range(0, 2)), 1'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
